board_move_ctrl: RTL and testbench

Parametrised cursor and move-commit controller for the chess board store. It replaces the fixed 8×8 row/column position counter with a ROWS×COLS cursor that wraps in both axes and has edge-detected button inputs. It adds a select/commit state machine that picks up a piece of the side to move and writes it to a destination square in the board memory. It sits between the front-panel buttons and the board register array. Move legality beyond colour ownership belongs to the move-generator block, not this one.

---
 rtl/chess_pkg.sv | 26 ++
 rtl/board_move_ctrl_if.sv | 27 ++
 rtl/board_move_ctrl_btn_edge.sv | 23 ++
 rtl/board_move_ctrl.sv | 135 +++++++++++++
 tb/tb_board_move_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/chess_pkg.sv
// Piece-word encoding and controller state type shared by the board store blocks.
package chess_pkg;

  localparam int OCC_BIT   = 0;
  localparam int COLOR_BIT = 1;
  localparam int TYPE_LSB  = 2;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    WR_DST   = 2'd2,
    WR_SRC   = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/board_move_ctrl_if.sv
// Board register-array access bus: combinational read port plus one-cycle write strobe.
interface board_move_ctrl_if #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int PIECE_W = 5
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic [RW-1:0]      rd_row;
  logic [CW-1:0]      rd_col;
  logic [PIECE_W-1:0] rd_data;
  logic               wr_en;
  logic [RW-1:0]      wr_row;
  logic [CW-1:0]      wr_col;
  logic [PIECE_W-1:0] wr_data;

  modport master (
    output rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_row, rd_col, wr_en, wr_row, wr_col, wr_data,
    output rd_data
  );
endinterface

// File: rtl/board_move_ctrl_btn_edge.sv
// Registered rising-edge detector for a vector of already-synchronised buttons.
module btn_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_p0 <= '0;
      rise    <= '0;
    end else begin
      prev_p0 <= btn;
      rise    <= btn & ~prev_p0;
    end
  end

endmodule

// File: rtl/board_move_ctrl.sv
// Wrapping board cursor plus select/commit FSM that moves a piece of the side to move.
module board_move_ctrl
  import chess_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int PIECE_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rowChange,
  input  logic                      columnChange,
  input  logic                      UP,
  input  logic                      select,
  input  logic                      cancel,
  board_move_ctrl_if.master         bus,
  output logic [$clog2(ROWS)-1:0]   cur_row,
  output logic [$clog2(COLS)-1:0]   cur_col,
  output logic [$clog2(ROWS)-1:0]   src_row,
  output logic [$clog2(COLS)-1:0]   src_col,
  output logic                      selected,
  output logic                      turn,
  output logic                      move_done,
  output logic                      reject
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic [3:0]         btn_rise;
  logic               row_e, col_e, sel_e, can_e;
  logic               own_piece, at_src;
  logic [PIECE_W-1:0] piece;
  ctrl_state_t        state;

  btn_edge #(.W(4)) u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .btn   ({cancel, select, columnChange, rowChange}),
    .rise  (btn_rise)
  );

  assign {can_e, sel_e, col_e, row_e} = btn_rise;

  assign bus.rd_row = cur_row;
  assign bus.rd_col = cur_col;
  assign selected   = (state == SELECTED);
  assign own_piece  = bus.rd_data[OCC_BIT] && (bus.rd_data[COLOR_BIT] == turn);
  assign at_src     = (cur_row == src_row) && (cur_col == src_col);

  // Compare-to-bound wrap keeps non-power-of-two boards inside range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_row <= '0;
      cur_col <= '0;
    end else begin
      if (row_e) begin
        if (UP) cur_row <= (cur_row == RW'(ROWS-1)) ? '0 : cur_row + RW'(1);
        else    cur_row <= (cur_row == '0) ? RW'(ROWS-1) : cur_row - RW'(1);
      end
      if (col_e) begin
        if (UP) cur_col <= (cur_col == CW'(COLS-1)) ? '0 : cur_col + CW'(1);
        else    cur_col <= (cur_col == '0) ? CW'(COLS-1) : cur_col - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      turn        <= WHITE;
      src_row     <= '0;
      src_col     <= '0;
      piece       <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_row  <= '0;
      bus.wr_col  <= '0;
      bus.wr_data <= '0;
      move_done   <= 1'b0;
      reject      <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      move_done <= 1'b0;
      reject    <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_e) begin
            if (own_piece) begin
              src_row <= cur_row;
              src_col <= cur_col;
              piece   <= bus.rd_data;
              state   <= SELECTED;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        SELECTED: begin
          if (can_e) begin
            state <= IDLE;
          end else if (sel_e) begin
            if (at_src) begin
              state <= IDLE;
            end else if (own_piece) begin
              src_row <= cur_row;
              src_col <= cur_col;
              piece   <= bus.rd_data;
            end else begin
              bus.wr_en   <= 1'b1;
              bus.wr_row  <= cur_row;
              bus.wr_col  <= cur_col;
              bus.wr_data <= piece;
              state       <= WR_DST;
            end
          end
        end
        // Destination write is on the bus now; queue the source clear.
        WR_DST: begin
          bus.wr_en   <= 1'b1;
          bus.wr_row  <= src_row;
          bus.wr_col  <= src_col;
          bus.wr_data <= '0;
          move_done   <= 1'b1;
          state       <= WR_SRC;
        end
        WR_SRC: begin
          turn  <= ~turn;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_move_ctrl.sv
// Directed bench for board_move_ctrl: cursor wrap, edge detect, reject, commit, reselect, reset.
module tb_board_move_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rowChange = 1'b0, columnChange = 1'b0, UP = 1'b0, select = 1'b0, cancel = 1'b0;

  always #5 clk = ~clk;

  board_move_ctrl_if #(.ROWS(8), .COLS(8), .PIECE_W(5)) bus ();
  board_move_ctrl_if #(.ROWS(5), .COLS(8), .PIECE_W(5)) bus5 ();

  logic [2:0] cur_row, cur_col, src_row, src_col;
  logic       selected, turn, move_done, reject;
  logic [2:0] cur_row5, cur_col5, src_row5, src_col5;
  logic       selected5, turn5, move_done5, reject5;

  board_move_ctrl #(.ROWS(8), .COLS(8), .PIECE_W(5)) dut (
    .clk(clk), .reset(reset), .rowChange(rowChange), .columnChange(columnChange),
    .UP(UP), .select(select), .cancel(cancel), .bus(bus.master),
    .cur_row(cur_row), .cur_col(cur_col), .src_row(src_row), .src_col(src_col),
    .selected(selected), .turn(turn), .move_done(move_done), .reject(reject)
  );

  board_move_ctrl #(.ROWS(5), .COLS(8), .PIECE_W(5)) dut5 (
    .clk(clk), .reset(reset), .rowChange(rowChange), .columnChange(columnChange),
    .UP(UP), .select(select), .cancel(cancel), .bus(bus5.master),
    .cur_row(cur_row5), .cur_col(cur_col5), .src_row(src_row5), .src_col(src_col5),
    .selected(selected5), .turn(turn5), .move_done(move_done5), .reject(reject5)
  );

  // Board store model: combinational read, write on the clock edge.
  logic [4:0] board [8][8];
  int wr_cnt = 0;
  assign bus.rd_data  = board[bus.rd_row][bus.rd_col];
  assign bus5.rd_data = 5'b00000;

  always @(posedge clk) begin
    if (bus.wr_en) begin
      board[bus.wr_row][bus.wr_col] <= bus.wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic r, input logic c, input logic s, input logic x);
    rowChange = r; columnChange = c; select = s; cancel = x;
    tick();
    rowChange = 1'b0; columnChange = 1'b0; select = 1'b0; cancel = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        board[r][c] = 5'b00000;
    board[6][4] = 5'b00101;  // white pawn
    board[1][0] = 5'b00111;  // black pawn
    board[0][0] = 5'b10011;  // black rook

    tick(); tick();
    check("rst_cur_row", cur_row, 0);
    check("rst_cur_col", cur_col, 0);
    check("rst_wr_en", bus.wr_en, 0);
    reset = 1'b0;
    tick();
    check("rst_turn", turn, 0);
    check("rst_selected", selected, 0);
    check("rst_src", {src_row, src_col}, 0);
    check("rst_pulses", {move_done, reject}, 0);
    check("rst_wr_addr_data", {bus.wr_row, bus.wr_col, bus.wr_data}, 0);

    // Wrap in both directions, both board sizes.
    UP = 1'b0; press(1, 0, 0, 0);
    check("wrap_down_row8", cur_row, 7);
    check("wrap_down_row5", cur_row5, 4);
    UP = 1'b1; press(1, 0, 0, 0);
    check("wrap_up_row8", cur_row, 0);
    check("wrap_up_row5", cur_row5, 0);
    UP = 1'b0; press(0, 1, 0, 0);
    check("wrap_down_col", cur_col, 7);
    UP = 1'b1; press(0, 1, 0, 0);
    check("wrap_up_col", cur_col, 0);
    press(1, 1, 0, 0);
    check("both_axes", {cur_row, cur_col}, {3'd1, 3'd1});
    UP = 1'b0; press(1, 1, 0, 0);
    check("both_axes_back", {cur_row, cur_col}, 0);

    // Held button steps once.
    UP = 1'b1; rowChange = 1'b1;
    repeat (20) tick();
    rowChange = 1'b0; tick();
    check("held_row", cur_row, 1);

    // Cursor at (1,0) holds a black pawn while white is to move.
    press(0, 0, 1, 0);
    check("reject_pulse", reject, 1);
    check("reject_selected", selected, 0);
    tick();
    check("reject_one_cycle", reject, 0);

    // Walk to (6,4), pick up the white pawn.
    repeat (4) press(1, 1, 0, 0);
    press(1, 0, 0, 0);
    check("cursor_6_4", {cur_row, cur_col}, {3'd6, 3'd4});
    check("rd_addr", {bus.rd_row, bus.rd_col}, {3'd6, 3'd4});
    press(0, 0, 1, 0);
    check("pick_selected", selected, 1);
    check("pick_src", {src_row, src_col}, {3'd6, 3'd4});
    UP = 1'b0; press(1, 0, 0, 0); press(1, 0, 0, 0);
    check("cursor_4_4", {cur_row, cur_col}, {3'd4, 3'd4});
    press(0, 0, 1, 0);
    check("dst_wr", {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data}, {1'b1, 3'd4, 3'd4, 5'b00101});
    check("dst_turn", turn, 0);
    tick();
    check("src_wr", {bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data}, {1'b1, 3'd6, 3'd4, 5'b00000});
    check("src_move_done", move_done, 1);
    check("src_turn_held", turn, 0);
    tick();
    check("post_wr_en", bus.wr_en, 0);
    check("post_move_done", move_done, 0);
    check("post_turn", turn, 1);
    check("board_dst", board[4][4], 5'b00101);
    check("board_src", board[6][4], 5'b00000);
    check("wr_cnt_commit", wr_cnt, 2);

    // Black to move: select pawn at (1,0), reselect rook at (0,0), then select+cancel.
    repeat (3) press(1, 1, 0, 0);
    press(0, 1, 0, 0);
    check("cursor_1_0", {cur_row, cur_col}, {3'd1, 3'd0});
    press(0, 0, 1, 0);
    check("black_pick", {selected, src_row, src_col}, {1'b1, 3'd1, 3'd0});
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    check("reselect_src", {selected, src_row, src_col}, {1'b1, 3'd0, 3'd0});
    press(0, 0, 1, 1);
    check("cancel_wins", selected, 0);
    tick();
    check("cancel_no_write", wr_cnt, 2);
    press(0, 0, 1, 0);
    check("pick_again", selected, 1);
    press(0, 0, 1, 0);
    check("deselect_at_src", {selected, reject}, 0);

    // Reset during WR_DST drops both writes.
    press(0, 0, 1, 0);
    UP = 1'b1; press(1, 0, 0, 0); press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    check("pre_reset_dst", {bus.wr_en, bus.wr_row, bus.wr_col}, {1'b1, 3'd2, 3'd0});
    reset = 1'b1;
    #1;
    check("reset_async_wr_en", bus.wr_en, 0);
    tick();
    reset = 1'b0;
    tick();
    check("reset_wr_en", bus.wr_en, 0);
    check("reset_turn", turn, 0);
    check("reset_cursor", {cur_row, cur_col}, 0);
    check("reset_selected", {selected, move_done}, 0);
    check("reset_no_writes", wr_cnt, 2);
    check("reset_board_src", board[0][0], 5'b10011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
